// File: rtl/mem_pkg.sv
// Shared data-memory types: access width, arbiter grant encoding, and default sizes.
package mem_pkg;

  localparam int DMemAddrWidth      = 12;
  localparam int DefaultStarveLimit = 4;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef enum logic {
    GRANT_CORE = 1'b0,
    GRANT_EXT  = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating 4-bit count of consecutive cycles the external requester was refused.
module starve_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  input  logic [3:0] limit,
  output logic       hit
);

  logic [3:0] count_reg;
  logic [3:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count_reg != limit)) begin
      count_next = count_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign hit = (count_reg == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the core and an external requester.
// Define DMEM_ARB_STARVE_EN to let a starved external requester force one grant.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int AddrWidth   = DMemAddrWidth,
  parameter int StarveLimit = DefaultStarveLimit
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_req,
  input  logic                 core_we,
  input  mem_width_t           core_width,
  input  logic [AddrWidth-1:0] core_addr,
  input  logic [31:0]          core_wdata,
  output logic [31:0]          core_rdata,
  output logic                 core_stall,
  input  logic                 ext_valid,
  output logic                 ext_ready,
  input  logic                 ext_we,
  input  mem_width_t           ext_width,
  input  logic [AddrWidth-1:0] ext_addr,
  input  logic [31:0]          ext_wdata,
  output logic                 ext_rsp_valid,
  output logic [31:0]          ext_rdata,
  output logic                 mem_we,
  output mem_width_t           mem_width,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 grant_ext
);

  arb_grant_t  grant;
  logic        starve_hit;
  logic        ext_xfer;
  logic        rsp_valid_reg;
  logic [31:0] ext_rdata_reg;

`ifdef DMEM_ARB_STARVE_EN
  // Counter clears on every transfer, so a forced grant can never repeat back to back.
  starve_counter u_starve_counter (
    .clk   (clk),
    .reset (reset),
    .clear (!ext_valid || ext_xfer),
    .inc   (ext_valid && !ext_xfer),
    .limit (4'(StarveLimit)),
    .hit   (starve_hit)
  );
`else
  // StarveLimit is never 0 (legal range 1..15), so this ties the hit low.
  assign starve_hit = (StarveLimit == 0);
`endif

  always_comb begin
    grant = GRANT_CORE;
    if (ext_valid && (!core_req || starve_hit)) begin
      grant = GRANT_EXT;
    end
  end

  assign grant_ext = (grant == GRANT_EXT);
  assign ext_ready = grant_ext;
  assign ext_xfer  = ext_valid && ext_ready;

`ifdef DMEM_ARB_STARVE_EN
  assign core_stall = core_req && grant_ext;
`else
  assign core_stall = 1'b0;
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_width = core_width;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (grant == GRANT_EXT) begin
      mem_we    = ext_we;
      mem_width = ext_width;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (core_req) begin
      mem_we = core_we;
    end
  end

  assign core_rdata = mem_rdata;

  // Writes pulse the response too, but leave the last read data in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_reg <= 1'b0;
      ext_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= ext_xfer;
      if (ext_xfer && !ext_we) begin
        ext_rdata_reg <= mem_rdata;
      end
    end
  end

  assign ext_rsp_valid = rsp_valid_reg;
  assign ext_rdata     = ext_rdata_reg;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, default DMemAddrWidth, data-memory byte address width.
REQ-002 SHALL have parameter StarveLimit, default 4, consecutive refused ext cycles before forced grant (range 1..15).
REQ-003 SHALL have port clk  input  1  the core clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports core_req/core_we  input  1/1  core memory access this cycle / access is a write.
REQ-006 SHALL have ports core_width  input  mem_width_t, core_addr  input  AddrWidth, core_wdata  input  32  core access attributes.
REQ-007 SHALL have ports core_rdata  output  32, core_stall  output  1  read data / core must hold its PC this cycle.
REQ-008 SHALL have ports ext_valid  input  1, ext_ready  output  1, ext_we  input  1, ext_width  input  mem_width_t, ext_addr  input  AddrWidth, ext_wdata  input  32  external request channel.
REQ-009 SHALL have ports ext_rsp_valid  output  1, ext_rdata  output  32  external response channel.
REQ-010 SHALL have ports mem_we  output  1, mem_width  output  mem_width_t, mem_addr  output  AddrWidth, mem_wdata  output  32, mem_rdata  input  32  to dmem.
REQ-011 SHALL have port grant_ext  output  1  ext owns the memory port this cycle.

Function
REQ-012 SHALL treat dmem as combinational read, write committed at rising edge.
REQ-013 SHALL grant ext (grant_ext=1) when ext_valid=1 and (core_req=0 or forced grant per REQ-017); otherwise grant core.
REQ-014 SHALL drive ext_ready = grant_ext; transfer occurs on ext_valid & ext_ready.
REQ-015 SHALL mux mem_* from the granted requester; with no requester, mem_we=0 and address/data from core.
REQ-016 SHALL drive core_stall = core_req & grant_ext, combinationally; core_rdata = mem_rdata.
REQ-017 SHALL keep 4-bit starve_cnt: increments (saturating at StarveLimit) each cycle ext_valid=1 and not granted; clears on ext transfer or ext_valid=0; forced grant when starve_cnt==StarveLimit.
REQ-018 SHALL register read data: on ext read transfer, ext_rdata<=mem_rdata and ext_rsp_valid=1 exactly one cycle later; ext writes also pulse ext_rsp_valid one cycle later with ext_rdata unchanged.
REQ-019 SHALL never grant ext twice consecutively by force while core_req=1 (guaranteed by counter clear).
REQ-020 SHALL accept back-to-back ext transfers when core idle, one per cycle.

Reset
REQ-021 SHALL on reset low: starve_cnt=0, ext_rsp_valid=0, ext_rdata=0; outputs grant_ext, ext_ready, core_stall, mem_we then follow combinationally from inputs.
REQ-022 SHALL drop a pending response when reset asserts between transfer and response.

Configuration
REQ-023 SHALL implement starvation escalation only when DMEM_ARB_STARVE_EN is defined.
REQ-024 SHALL, without DMEM_ARB_STARVE_EN, use strict core priority: no counter, core_stall constant 0, ext granted only when core_req=0.

Structure
REQ-025 SHALL place mem_width_t reuse and a new arb_grant_t enum (GRANT_CORE, GRANT_EXT) plus DefaultStarveLimit in mem_pkg.
REQ-026 SHALL implement the counter as sub-module starve_counter (clear, inc, limit, hit outputs).

Verification
REQ-027 Core read 0x10 only, mem_rdata=0xDEADBEEF -> core_rdata=0xDEADBEEF, core_stall=0, grant_ext=0.
REQ-028 Core idle, ext write 0x20 data 0x12345678 -> ext_ready=1, mem_we=1 mem_addr=0x20, ext_rsp_valid=1 next cycle.
REQ-029 STARVE_EN, StarveLimit=4, core_req and ext_valid held high -> grant_ext on 5th cycle only, core_stall=1 that cycle, pattern repeats every 5 cycles.
REQ-030 Without STARVE_EN, same stimulus 20 cycles -> grant_ext never, core_stall never.
REQ-031 Ext read accepted, reset asserted next cycle -> ext_rsp_valid=0, starve_cnt=0 after release.
REQ-032 Core idle, ext reads 0x0,0x4,0x8 consecutive -> three transfers, responses in three consecutive cycles with matching data.
